// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall / flush / forwarding controller for a 5-stage RISC-V pipeline
// (IF/ID/EX/MEM/WB). It keeps shadow copies of the register-usage fields of the
// instructions in EX, MEM and WB, and from them derives:
//   - pipeline register enables and synchronous flushes,
//   - the PC enable,
//   - the EX-stage operand forwarding selects,
//   - sequencing for multi-cycle divides and data-memory wait states.
//
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   id_rs1, id_rs2, id_rd       register addresses of the ID instruction
//   id_uses_rs1, id_uses_rs2    ID instruction actually reads rs1 / rs2
//   id_reg_write                ID instruction writes rd
//   id_mem_read                 ID instruction is a load
//   id_is_div                   ID instruction is a divide/remainder
//   ex_branch_mispredict        branch resolved in EX was mispredicted
//   dmem_stall                  data memory not ready for the MEM access
//   pc_enable                   PC register enable
//   if_id/id_ex/ex_mem/mem_wb_enable  pipeline register enables
//   if_id/id_ex/ex_mem_flush    load a NOP into that register on the next
//                               enabled edge
//   fwd_a_sel, fwd_b_sel        0 = register file, 1 = EX/MEM, 2 = MEM/WB
//   div_busy                    divide in EX still computing
//
// Handshake note: there is no valid/ready pairing here. Every enable is a
// per-cycle "advance" qualifier; a flush only takes effect when the matching
// enable is also high on that edge.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DIV_CYCLES     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_is_div,
    input  logic                      ex_branch_mispredict,
    input  logic                      dmem_stall,
    output logic                      pc_enable,
    output logic                      if_id_enable,
    output logic                      id_ex_enable,
    output logic                      ex_mem_enable,
    output logic                      mem_wb_enable,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic                      ex_mem_flush,
    output logic [1:0]                fwd_a_sel,
    output logic [1:0]                fwd_b_sel,
    output logic                      div_busy
);

    localparam int                      CNT_W    = $clog2(DIV_CYCLES) + 1;
    localparam logic [CNT_W-1:0]        DIV_LAST = CNT_W'(DIV_CYCLES - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] REG_X0 = '0;

    // Control case selected this cycle, in priority order.
    localparam logic [2:0] CASE_NORMAL   = 3'd0;
    localparam logic [2:0] CASE_DMEM     = 3'd1;
    localparam logic [2:0] CASE_DIV      = 3'd2;
    localparam logic [2:0] CASE_FLUSH    = 3'd3;
    localparam logic [2:0] CASE_LOAD_USE = 3'd4;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // EX shadow
    logic [REG_ADDR_WIDTH-1:0] ex_rs1;
    logic [REG_ADDR_WIDTH-1:0] ex_rs2;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_reg_write;
    logic                      ex_mem_read;
    logic                      ex_is_div;
    // MEM / WB shadows
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic                      mem_reg_write;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic                      wb_reg_write;

    logic [CNT_W-1:0]          div_cnt;

    logic                      load_use;
    logic                      div_busy_int;
    logic [2:0]                ctrl_case;

    // Un-forced control values; the reset override is applied at the ports.
    logic c_pc_en, c_if_id_en, c_id_ex_en, c_ex_mem_en, c_mem_wb_en;
    logic c_if_id_fl, c_id_ex_fl, c_ex_mem_fl;
    logic [1:0] c_fwd_a, c_fwd_b;

    // ------------------------------------------------------------------
    // Hazard detection and case selection
    // ------------------------------------------------------------------
    always_comb begin
        load_use = ex_mem_read && ex_reg_write && (ex_rd != REG_X0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));

        // Last divide cycle is not busy: the result is ready and EX drains.
        div_busy_int = ex_is_div && (div_cnt != DIV_LAST);

        if (dmem_stall)                ctrl_case = CASE_DMEM;
        else if (div_busy_int)         ctrl_case = CASE_DIV;
        else if (ex_branch_mispredict) ctrl_case = CASE_FLUSH;
        else if (load_use)             ctrl_case = CASE_LOAD_USE;
        else                           ctrl_case = CASE_NORMAL;
    end

    always_comb begin
        c_pc_en     = 1'b1;
        c_if_id_en  = 1'b1;
        c_id_ex_en  = 1'b1;
        c_ex_mem_en = 1'b1;
        c_mem_wb_en = 1'b1;
        c_if_id_fl  = 1'b0;
        c_id_ex_fl  = 1'b0;
        c_ex_mem_fl = 1'b0;
        case (ctrl_case)
            CASE_DMEM: begin
                c_pc_en     = 1'b0;
                c_if_id_en  = 1'b0;
                c_id_ex_en  = 1'b0;
                c_ex_mem_en = 1'b0;
                c_mem_wb_en = 1'b0;
            end
            CASE_DIV: begin
                // Front end frozen behind the divide; bubbles flow into MEM.
                c_pc_en     = 1'b0;
                c_if_id_en  = 1'b0;
                c_id_ex_en  = 1'b0;
                c_ex_mem_fl = 1'b1;
            end
            CASE_FLUSH: begin
                c_if_id_fl  = 1'b1;
                c_id_ex_fl  = 1'b1;
            end
            CASE_LOAD_USE: begin
                // Hold the consumer in ID, send a bubble into EX.
                c_pc_en     = 1'b0;
                c_if_id_en  = 1'b0;
                c_id_ex_fl  = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Forwarding: the younger producer (MEM) wins over WB.
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] src,
        input logic [REG_ADDR_WIDTH-1:0] m_rd,
        input logic                      m_we,
        input logic [REG_ADDR_WIDTH-1:0] w_rd,
        input logic                      w_we
    );
        if (m_we && (m_rd != REG_X0) && (m_rd == src))      return FWD_MEM;
        else if (w_we && (w_rd != REG_X0) && (w_rd == src)) return FWD_WB;
        else                                                return FWD_RF;
    endfunction

    always_comb begin
        c_fwd_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        c_fwd_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    end

    // ------------------------------------------------------------------
    // Output stage: reset forces a benign "everything flows" pattern.
    // ------------------------------------------------------------------
    always_comb begin
        pc_enable     = reset | c_pc_en;
        if_id_enable  = reset | c_if_id_en;
        id_ex_enable  = reset | c_id_ex_en;
        ex_mem_enable = reset | c_ex_mem_en;
        mem_wb_enable = reset | c_mem_wb_en;
        if_id_flush   = ~reset & c_if_id_fl;
        id_ex_flush   = ~reset & c_id_ex_fl;
        ex_mem_flush  = ~reset & c_ex_mem_fl;
        fwd_a_sel     = reset ? FWD_RF : c_fwd_a;
        fwd_b_sel     = reset ? FWD_RF : c_fwd_b;
        div_busy      = ~reset & div_busy_int;
    end

    // ------------------------------------------------------------------
    // Shadow registers and divide counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_is_div     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            div_cnt       <= '0;
        end else begin
            if (c_id_ex_en) begin
                if (c_id_ex_fl) begin
                    ex_rs1       <= '0;
                    ex_rs2       <= '0;
                    ex_rd        <= '0;
                    ex_reg_write <= 1'b0;
                    ex_mem_read  <= 1'b0;
                    ex_is_div    <= 1'b0;
                end else begin
                    ex_rs1       <= id_rs1;
                    ex_rs2       <= id_rs2;
                    ex_rd        <= id_rd;
                    ex_reg_write <= id_reg_write;
                    ex_mem_read  <= id_mem_read;
                    ex_is_div    <= id_is_div;
                end
            end

            if (c_ex_mem_en) begin
                if (c_ex_mem_fl) begin
                    mem_rd        <= '0;
                    mem_reg_write <= 1'b0;
                end else begin
                    mem_rd        <= ex_rd;
                    mem_reg_write <= ex_reg_write;
                end
            end

            if (c_mem_wb_en) begin
                wb_rd        <= mem_rd;
                wb_reg_write <= mem_reg_write;
            end

            // Counter wraps on the final cycle, so it is back at zero when
            // the divide leaves EX.
            if (ex_is_div && !dmem_stall) begin
                if (div_cnt == DIV_LAST) div_cnt <= '0;
                else                     div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed-vector bench for pipeline_hazard_ctrl (DIV_CYCLES = 4). Inputs are
// driven 1 ns after the rising edge, outputs are sampled 1 ns later, well
// away from the next edge. Expected values are hand-derived per vector.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, id_is_div;
  logic          ex_branch_mispredict, dmem_stall;
  logic          pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
  logic          if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          div_busy;

  logic [4:0]    en;
  logic [2:0]    fl;

  int n_checks = 0;
  int n_errors = 0;

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, ex_mem}
  assign en = {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable};
  assign fl = {if_id_flush, id_ex_flush, ex_mem_flush};

  pipeline_hazard_ctrl #(
    .REG_ADDR_WIDTH(RW),
    .DIV_CYCLES(4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .id_rs1               (id_rs1),
    .id_rs2               (id_rs2),
    .id_uses_rs1          (id_uses_rs1),
    .id_uses_rs2          (id_uses_rs2),
    .id_rd                (id_rd),
    .id_reg_write         (id_reg_write),
    .id_mem_read          (id_mem_read),
    .id_is_div            (id_is_div),
    .ex_branch_mispredict (ex_branch_mispredict),
    .dmem_stall           (dmem_stall),
    .pc_enable            (pc_enable),
    .if_id_enable         (if_id_enable),
    .id_ex_enable         (id_ex_enable),
    .ex_mem_enable        (ex_mem_enable),
    .mem_wb_enable        (mem_wb_enable),
    .if_id_flush          (if_id_flush),
    .id_ex_flush          (id_ex_flush),
    .ex_mem_flush         (ex_mem_flush),
    .fwd_a_sel            (fwd_a_sel),
    .fwd_b_sel            (fwd_b_sel),
    .div_busy             (div_busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_id(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                        input logic u1, input logic u2, input logic [RW-1:0] rd,
                        input logic rw, input logic mr, input logic dv);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_is_div = dv;
  endtask

  task automatic id_nop();
    set_id('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // advance one clock, land 1 ns past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle after an input change
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    id_nop();
    ex_branch_mispredict = 1'b0;
    dmem_stall = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // ---- reset state, with hostile inputs that must be masked ----
    reset = 1'b1;
    id_nop();
    ex_branch_mispredict = 1'b1;
    dmem_stall = 1'b1;
    settle();
    check("rst_en", en, 5'b11111);
    check("rst_fl", fl, 3'b000);
    check("rst_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);
    check("rst_busy", div_busy, 1'b0);
    do_reset();
    settle();
    check("post_rst_en", en, 5'b11111);

    // ---- load-use: lw x5,0(x1) ; add x6,x5,x1 ----
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
    tick();
    set_id(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6,x5,x1
    settle();
    check("lu_en", en, 5'b00111);
    check("lu_fl", fl, 3'b010);
    tick();                                                   // EX bubble, MEM lw
    settle();
    check("lu_after_en", en, 5'b11111);
    check("lu_after_fl", fl, 3'b000);
    tick();                                                   // EX add, WB lw
    id_nop();
    settle();
    check("lu_fwd_a", fwd_a_sel, 2'd2);
    check("lu_fwd_b", fwd_b_sel, 2'd0);

    // ---- load to x0 never stalls ----
    do_reset();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw x0
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6,x0,x0
    settle();
    check("lu_x0_en", en, 5'b11111);

    // ---- back-to-back ALU: add x3 ; sub x4,x3,x3 ----
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    id_nop();
    settle();
    check("b2b_fwd", {fwd_a_sel, fwd_b_sel}, {2'd1, 2'd1});

    // ---- one independent instruction between: WB forward ----
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // add x3
    tick();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // add x7
    tick();
    set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);   // sub x4,x3,x3
    tick();
    id_nop();
    settle();
    check("gap_fwd", {fwd_a_sel, fwd_b_sel}, {2'd2, 2'd2});

    // ---- both MEM and WB write x3: MEM wins ----
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(5'd2, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    id_nop();
    settle();
    check("prio_fwd", {fwd_a_sel, fwd_b_sel}, {2'd1, 2'd1});

    // ---- rd = x0: no forwarding ----
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);   // add x0
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);   // sub x4,x0,x0
    tick();
    id_nop();
    settle();
    check("x0_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);

    // ---- divide, 4 cycles: 3 busy then drain; result forwards from MEM ----
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);   // div x8,x1,x2
    tick();
    set_id(5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);   // addi x9,x8,0
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("div_busy_%0d", i), div_busy, 1'b1);
      check($sformatf("div_en_%0d", i), en, 5'b00011);
      check($sformatf("div_fl_%0d", i), fl, 3'b001);
      tick();
    end
    settle();
    check("div_done_busy", div_busy, 1'b0);
    check("div_done_en", en, 5'b11111);
    check("div_done_fl", fl, 3'b000);
    tick();                                                   // EX addi, MEM div
    id_nop();
    settle();
    check("div_fwd_a", fwd_a_sel, 2'd1);
    check("div_gone_busy", div_busy, 1'b0);

    // ---- divide with a 3-cycle dmem stall after its first cycle ----
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    tick();
    id_nop();
    settle();
    check("dvs_busy0", div_busy, 1'b1);
    tick();                                                   // div_cnt = 1
    dmem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("dvs_stall_en_%0d", i), en, 5'b00000);
      check($sformatf("dvs_stall_fl_%0d", i), fl, 3'b000);
      check($sformatf("dvs_stall_busy_%0d", i), div_busy, 1'b1);
      tick();
    end
    dmem_stall = 1'b0;
    settle();
    check("dvs_busy1", div_busy, 1'b1);
    check("dvs_en1", en, 5'b00011);
    tick();
    settle();
    check("dvs_busy2", div_busy, 1'b1);
    tick();
    settle();
    check("dvs_done_busy", div_busy, 1'b0);
    check("dvs_done_en", en, 5'b11111);
    tick();
    settle();
    check("dvs_after_busy", div_busy, 1'b0);

    // ---- mispredict with a simultaneous load-use condition ----
    do_reset();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
    tick();
    set_id(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6,x5,x1
    ex_branch_mispredict = 1'b1;
    settle();
    check("mp_lu_en", en, 5'b11111);
    check("mp_lu_fl", fl, 3'b110);
    tick();
    // ---- mispredict held across a dmem stall ----
    dmem_stall = 1'b1;
    settle();
    check("mp_stall_en", en, 5'b00000);
    check("mp_stall_fl", fl, 3'b000);
    tick();
    dmem_stall = 1'b0;
    settle();
    check("mp_rel_en", en, 5'b11111);
    check("mp_rel_fl", fl, 3'b110);
    tick();
    ex_branch_mispredict = 1'b0;
    id_nop();
    settle();
    check("mp_clear_fl", fl, 3'b000);

    // ---- reset pulsed mid-divide (div_cnt = 2) ----
    do_reset();
    set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    tick();                                                   // cnt 0
    id_nop();
    tick();                                                   // cnt 1
    tick();                                                   // cnt 2
    settle();
    check("rdiv_pre_busy", div_busy, 1'b1);
    reset = 1'b1;
    settle();
    check("rdiv_busy", div_busy, 1'b0);
    check("rdiv_en", en, 5'b11111);
    check("rdiv_fl", fl, 3'b000);
    tick();
    reset = 1'b0;
    settle();
    check("rdiv_rel_busy", div_busy, 1'b0);
    check("rdiv_rel_en", en, 5'b11111);
    check("rdiv_rel_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);
    tick();
    settle();
    check("rdiv_next_busy", div_busy, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall, flush and forwarding controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Drives the enable and synchronous-flush controls of the pipeline registers, the PC enable, and the 2-bit selects of the EX-stage operand forwarding muxes.
- Tracks destination/source info of in-flight instructions in internal shadow registers.
- Sequences multi-cycle divides and data-memory wait states.

Parameters:
REG_ADDR_WIDTH, 5, register-file address width
DIV_CYCLES, 32, total cycles a divide instruction occupies EX (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
id_rs1  input  REG_ADDR_WIDTH  source 1 of instruction in ID
id_rs2  input  REG_ADDR_WIDTH  source 2 of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
id_rd  input  REG_ADDR_WIDTH  destination of ID instruction
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
id_is_div  input  1  ID instruction is DIV/DIVU/REM/REMU
ex_branch_mispredict  input  1  branch resolved in EX was mispredicted
dmem_stall  input  1  data memory not ready for MEM-stage access
pc_enable  output  1  PC register enable
if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable  output  1 each  pipeline register enables
if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  load NOP into that register on the next enabled edge
fwd_a_sel, fwd_b_sel  output  2 each  EX operand select: 0=register file, 1=EX/MEM result, 2=MEM/WB result; 3 is never driven
div_busy  output  1  divide in EX still computing

Behaviour:
- Reset is asynchronous and active-high on clk.
  - Clears all shadow registers and the divide counter.
  - While reset is high, outputs are forced: all enables=1, all flushes=0, fwd selects=0, div_busy=0.
- Shadow stages:
  - EX shadow holds {rs1, rs2, rd, reg_write, mem_read, is_div}; MEM and WB shadows hold {rd, reg_write}.
  - EX shadow loads the id_* fields when id_ex_enable=1, or zeros if id_ex_flush=1.
  - MEM shadow loads from EX when ex_mem_enable=1, or zeros if ex_mem_flush=1.
  - WB shadow loads from MEM when mem_wb_enable=1.
- Load-use hazard (combinational). Asserted when all of the following hold:
  - ex_mem_read=1, ex_reg_write=1, ex_rd!=0;
  - (id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd).
- Divide sequencing:
  - Counter div_cnt, width $clog2(DIV_CYCLES)+1, reset 0.
  - While ex_is_div=1 and dmem_stall=0: div_cnt wraps to 0 if div_cnt==DIV_CYCLES-1, otherwise increments.
  - div_busy = ex_is_div and (div_cnt != DIV_CYCLES-1). With DIV_CYCLES=1, div_busy is never asserted.
- Priority, highest first; exactly one case applies per cycle:
  1. dmem_stall=1: all enables=0, all flushes=0, div_cnt holds, shadows hold.
  2. div_busy=1: pc/if_id/id_ex enables=0; ex_mem_enable=1 with ex_mem_flush=1 (bubble); mem_wb_enable=1.
  3. ex_branch_mispredict=1: all enables=1; if_id_flush=1 and id_ex_flush=1 for that single cycle. A load-use hazard in the same cycle is ignored.
  4. Load-use hazard: pc_enable=0, if_id_enable=0; id_ex_enable=1 with id_ex_flush=1; ex_mem and mem_wb enables=1.
  5. Otherwise: all enables=1, all flushes=0.
- Mispredict held across dmem_stall: EX is frozen, so the input stays high and the flush is applied on the first cycle after the stall releases.
- Forwarding, operand A (combinational, every cycle including stalls):
  - fwd_a_sel=1 if mem_reg_write and mem_rd!=0 and mem_rd==ex_rs1;
  - else 2 if wb_reg_write and wb_rd!=0 and wb_rd==ex_rs1;
  - else 0. The MEM match wins when both match.
- Forwarding, operand B: same rules as operand A using ex_rs2.
- Register x0 never causes a hazard or a forward.
- Reset asserted mid-divide or mid-stall aborts the operation; after release the first cycle is case 5 unless inputs dictate otherwise.

Test Plan:
- Load-use: lw x5 in EX, add x6,x5,x1 in ID → one cycle with pc_enable=0, if_id_enable=0, id_ex_flush=1. Next cycle no stall; when add reaches EX, fwd_a_sel=2.
- Back-to-back ALU: add x3 then sub x4,x3,x3 → fwd_a_sel=fwd_b_sel=1. Insert an independent instruction between them → both selects=2. Repeat with rd=x0 → both selects=0.
- Divide, DIV_CYCLES=4: div enters EX → div_busy=1 for exactly 3 cycles with ex_mem_flush=1 each cycle; 4th cycle all enables=1; div_cnt returns to 0.
- dmem_stall held 3 cycles during a divide → all enables=0, div_cnt frozen; div_busy total cycles unchanged.
- Mispredict with a simultaneous load-use condition → if_id_flush=id_ex_flush=1, pc_enable=1, no load-use stall. Mispredict together with dmem_stall → flushes only on the release cycle.
- Reset pulsed mid-divide (div_cnt=2) → div_busy=0 immediately, all enables=1; fwd selects=0 after release.
